// File: rtl/psum_acc_pkg.sv
// Shared field layout, FSM states and output clamp for the partial-sum accumulator.
package psum_acc_pkg;
  localparam int P3X3_LSB = 0;
  localparam int P3X3_W   = 32;
  localparam int P1X1_LSB = 32;
  localparam int P1X1_W   = 24;
  localparam int ID_LSB   = 56;
  localparam int ID_W     = 8;
  localparam int OUT_MAX  = 127;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/psum_buf.sv
// 1R1W synchronous-read psum RAM; a same-address read and write in one cycle returns the old word.
module psum_buf #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/psum_acc.sv
// Accumulates branch psums across input-channel passes; last pass emits ReLU+requantized int8.
// Beat accepted at t -> buffer read at t, accumulate at t+1, omap write strobe at t+2.
import psum_acc_pkg::*;

module psum_acc #(
  parameter int BUF_AW = 12,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_start,
  input  logic [7:0]  in_ch,
  input  logic [15:0] map_size,
  input  logic [4:0]  q_shift,
  output logic        acc_done,
  output logic        acc_err,
  input  logic [31:0] mac_array2psum_acc_addr,
  input  logic [63:0] mac_array2psum_acc_data,
  input  logic        mac_array2psum_acc_vld,
  output logic        mac_array2psum_acc_rdy,
  output logic [31:0] omap_waddr,
  output logic [7:0]  omap_wdata,
  output logic        omap_wen
);
  state_e            r_state;
  logic [7:0]        r_in_ch, r_pass_cnt;
  logic [15:0]       r_map_size, r_beat_cnt;
  logic [4:0]        r_q_shift;
  logic              r_rdy, r_done, r_err, r_drain;

  logic              r_s1_vld, r_s1_first, r_s1_last, r_s1_oob;
  logic [31:0]       r_s1_addr;
  logic [ACC_W-1:0]  r_s1_sum;
  logic              r_s2_vld;
  logic [BUF_AW-1:0] r_s2_addr;
  logic [ACC_W-1:0]  r_s2_acc;
  logic              r_omap_wen;
  logic [31:0]       r_omap_waddr;
  logic [7:0]        r_omap_wdata;

  logic              w_acc, w_oob, w_last_beat, w_last_pass, w_fwd, w_buf_we, w_out_we;
  logic [ACC_W-1:0]  w_sum, w_rd, w_base, w_s1_acc;
  logic [ACC_W:0]    w_pos, w_half, w_rnd;
  logic [7:0]        w_q;

  assign w_acc       = mac_array2psum_acc_vld && r_rdy;
  assign w_oob       = (mac_array2psum_acc_addr >> BUF_AW) != 32'd0;
  assign w_last_beat = (r_beat_cnt == r_map_size - 16'd1);
  assign w_last_pass = (r_pass_cnt == r_in_ch - 8'd1);
  assign w_sum = ACC_W'($signed(mac_array2psum_acc_data[P3X3_LSB +: P3X3_W]))
               + ACC_W'($signed(mac_array2psum_acc_data[P1X1_LSB +: P1X1_W]))
               + ACC_W'($signed(mac_array2psum_acc_data[ID_LSB +: ID_W]));

  // The previous beat's write lands on the same edge as this beat's read, so bypass the RAM.
  assign w_fwd    = r_s2_vld && (r_s2_addr == r_s1_addr[BUF_AW-1:0]);
  assign w_base   = w_fwd ? r_s2_acc : (r_s1_first ? '0 : w_rd);
  assign w_s1_acc = w_base + r_s1_sum;
  assign w_buf_we = r_s1_vld && !r_s1_oob && !r_s1_last;
  assign w_out_we = r_s1_vld && !r_s1_oob && r_s1_last;

  assign w_pos  = w_s1_acc[ACC_W-1] ? '0 : {1'b0, w_s1_acc};
  assign w_half = (r_q_shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (r_q_shift - 5'd1));
  assign w_rnd  = (w_pos + w_half) >> r_q_shift;
  assign w_q    = (w_rnd > (ACC_W+1)'(OUT_MAX)) ? 8'(OUT_MAX) : w_rnd[7:0];

  psum_buf #(.AW(BUF_AW), .DW(ACC_W)) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_s1_addr[BUF_AW-1:0]),
    .i_wdata (w_s1_acc),
    .i_raddr (mac_array2psum_acc_addr[BUF_AW-1:0]),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ch    <= '0;
      r_map_size <= '0;
      r_q_shift  <= '0;
      r_beat_cnt <= '0;
      r_pass_cnt <= '0;
      r_rdy      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_drain    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc && w_oob) r_err <= 1'b1;
      case (r_state)
        IDLE: if (acc_start) begin
          r_in_ch    <= in_ch;
          r_map_size <= map_size;
          r_q_shift  <= q_shift;
          r_beat_cnt <= '0;
          r_pass_cnt <= '0;
          r_err      <= 1'b0;
          if (in_ch == 8'd0 || map_size == 16'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= RUN;
            r_rdy   <= 1'b1;
          end
        end
        RUN: if (w_acc) begin
          if (w_last_beat) begin
            r_beat_cnt <= '0;
            r_pass_cnt <= r_pass_cnt + 8'd1;
            if (w_last_pass) begin
              r_state <= DRAIN;
              r_rdy   <= 1'b0;
              r_drain <= 1'b0;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
          end
        end
        // Two cycles let the final beat clear S1 and the omap register.
        DRAIN: if (r_drain) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_drain <= 1'b0;
        end else begin
          r_drain <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld     <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_oob     <= 1'b0;
      r_s1_addr    <= '0;
      r_s1_sum     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_addr    <= '0;
      r_s2_acc     <= '0;
      r_omap_wen   <= 1'b0;
      r_omap_waddr <= '0;
      r_omap_wdata <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_addr  <= mac_array2psum_acc_addr;
        r_s1_sum   <= w_sum;
        r_s1_first <= (r_pass_cnt == 8'd0);
        r_s1_last  <= w_last_pass;
        r_s1_oob   <= w_oob;
      end
      r_s2_vld   <= r_s1_vld && !r_s1_oob;
      r_s2_addr  <= r_s1_addr[BUF_AW-1:0];
      r_s2_acc   <= w_s1_acc;
      r_omap_wen <= w_out_we;
      if (w_out_we) begin
        r_omap_waddr <= r_s1_addr;
        r_omap_wdata <= w_q;
      end
    end
  end

  assign acc_done               = r_done;
  assign acc_err                = r_err;
  assign mac_array2psum_acc_rdy = r_rdy;
  assign omap_wen               = r_omap_wen;
  assign omap_waddr             = r_omap_waddr;
  assign omap_wdata             = r_omap_wdata;
endmodule

// File: tb/tb_psum_acc.sv
// Directed bench for psum_acc with a per-beat reference model and cycle-accurate output compare.
module tb_psum_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_start = 1'b0;
  logic [7:0]  in_ch = '0;
  logic [15:0] map_size = '0;
  logic [4:0]  q_shift = '0;
  logic        acc_done, acc_err;
  logic [31:0] mac_addr = '0;
  logic [63:0] mac_data = '0;
  logic        mac_vld = 1'b0;
  logic        mac_rdy;
  logic [31:0] omap_waddr;
  logic [7:0]  omap_wdata;
  logic        omap_wen;

  always #5 clk = ~clk;

  psum_acc dut (
    .clk(clk), .rst(rst), .acc_start(acc_start), .in_ch(in_ch), .map_size(map_size),
    .q_shift(q_shift), .acc_done(acc_done), .acc_err(acc_err),
    .mac_array2psum_acc_addr(mac_addr), .mac_array2psum_acc_data(mac_data),
    .mac_array2psum_acc_vld(mac_vld), .mac_array2psum_acc_rdy(mac_rdy),
    .omap_waddr(omap_waddr), .omap_wdata(omap_wdata), .omap_wen(omap_wen)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [31:0] addr; logic [7:0] d; } exp_t;
  exp_t exp_q[$];

  int m_buf [0:4095];
  int m_in_ch, m_map, m_qs, m_beats;
  bit m_busy = 0;
  int exp_done_cyc = -1;
  bit exp_err = 0;
  bit last_ok = 0;
  int last_cyc, last_addr, last_acc;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic [7:0] lit_out [0:15];

  function automatic int requant(input int acc, input int qs);
    longint r;
    r = (acc < 0) ? 0 : longint'(acc);
    if (qs > 0) r = (r + (longint'(1) << (qs - 1))) >> qs;
    return (r > 127) ? 127 : int'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int s, pass, acc, base, a;
    checks++;
    if (acc_done !== (cyc == exp_done_cyc)) begin
      errors++;
      $display("FAIL done_timing cyc=%0d act=%0b exp=%0b", cyc, acc_done, cyc == exp_done_cyc);
    end
    checks++;
    if (acc_err !== exp_err) begin
      errors++;
      $display("FAIL acc_err cyc=%0d act=%0b exp=%0b", cyc, acc_err, exp_err);
    end
    if (omap_wen) begin
      checks++;
      wr_cnt++;
      if (omap_waddr < 32'd16) lit_out[omap_waddr[3:0]] = omap_wdata;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL omap_unexpected cyc=%0d addr=%0d data=%0d", cyc, omap_waddr, $signed(omap_wdata));
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || omap_waddr !== e.addr || omap_wdata !== e.d) begin
          errors++;
          $display("FAIL omap_write act cyc=%0d addr=%0d data=%0d exp cyc=%0d addr=%0d data=%0d",
                   cyc, omap_waddr, $signed(omap_wdata), e.cyc, e.addr, $signed(e.d));
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL omap_missing cyc=%0d act=none exp addr=%0d data=%0d", cyc, e.addr, $signed(e.d));
    end
    if (acc_done) done_cnt++;

    if (rst) begin
      exp_q.delete();
      m_busy = 0;
      exp_done_cyc = -1;
      exp_err = 0;
      last_ok = 0;
    end else begin
      if (acc_start && !m_busy) begin
        m_in_ch = int'(in_ch);
        m_map = int'(map_size);
        m_qs = int'(q_shift);
        m_beats = 0;
        exp_err = 0;
        last_ok = 0;
        m_busy = 1;
        if (m_in_ch == 0 || m_map == 0) exp_done_cyc = cyc + 1;
      end
      if (mac_vld && mac_rdy) begin
        s = $signed(mac_data[31:0]) + int'($signed(mac_data[55:32])) + int'($signed(mac_data[63:56]));
        pass = m_beats / m_map;
        if (mac_addr >= 32'd4096) begin
          exp_err = 1;
          last_ok = 0;
        end else begin
          a = int'(mac_addr);
          if (last_ok && last_cyc == cyc - 1 && last_addr == a) base = last_acc;
          else base = (pass == 0) ? 0 : m_buf[a];
          acc = base + s;
          if (pass != m_in_ch - 1) m_buf[a] = acc;
          else exp_q.push_back('{cyc + 2, mac_addr, 8'(requant(acc, m_qs))});
          last_ok = 1;
          last_cyc = cyc;
          last_addr = a;
          last_acc = acc;
        end
        m_beats++;
        if (m_beats == m_in_ch * m_map) exp_done_cyc = cyc + 3;
      end
      if (m_busy && cyc == exp_done_cyc) m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic start(input int ic, input int ms, input int qs);
    tick();
    in_ch = 8'(ic);
    map_size = 16'(ms);
    q_shift = 5'(qs);
    acc_start = 1'b1;
    tick();
    acc_start = 1'b0;
  endtask

  task automatic send(input int addr, input int v3, input int v1, input int vid);
    int n = 0;
    mac_addr = 32'(addr);
    mac_data = {vid[7:0], v1[23:0], v3};
    mac_vld = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!mac_rdy && n < 200);
    if (!mac_rdy) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout addr=%0d act=0 exp=1", addr);
    end
    @(posedge clk);
    #1;
    mac_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 500) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int d0, w0;
    for (int i = 0; i < 16; i++) lit_out[i] = 8'h55;
    repeat (3) tick();
    chk("rst_rdy", int'(mac_rdy), 0);
    chk("rst_done", int'(acc_done), 0);
    chk("rst_err", int'(acc_err), 0);
    chk("rst_wen", int'(omap_wen), 0);
    chk("rst_waddr", int'(omap_waddr), 0);
    chk("rst_wdata", int'(omap_wdata), 0);
    rst = 1'b0;
    tick();

    // single pass, constant beats: 10 + 5 + 2 = 17 everywhere
    w0 = wr_cnt;
    d0 = done_cnt;
    start(1, 4, 0);
    for (int i = 0; i < 4; i++) send(i, 10, 5, 2);
    wait_done();
    for (int i = 0; i < 4; i++) chk($sformatf("t1_out%0d", i), int'(lit_out[i]), 17);
    chk("t1_writes", wr_cnt - w0, 4);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // back-to-back same address across three passes, forwarded chain 1..6
    start(3, 2, 0);
    for (int p = 0; p < 3; p++) begin
      send(0, 1, 0, 0);
      send(0, 1, 0, 0);
    end
    wait_done();
    chk("t2_fwd", int'(lit_out[0]), 6);

    // requant corners, with negative 1x1/identity fields exercising sign extension
    start(1, 1, 0); send(0, 0, -60, 10);    wait_done(); chk("rq_neg", int'(lit_out[0]), 0);
    start(1, 1, 0); send(0, 1100, -50, -50); wait_done(); chk("rq_sat", int'(lit_out[0]), 127);
    start(1, 1, 2); send(0, 0, 3, 3);       wait_done(); chk("rq_sh6", int'(lit_out[0]), 2);
    start(1, 1, 2); send(0, 5, 0, 0);       wait_done(); chk("rq_sh5", int'(lit_out[0]), 1);

    // random gaps and colliding addresses; pass 0 touches every address used later
    start(4, 16, 3);
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send((p == 0) ? (b % 8) : int'($urandom_range(0, 7)),
             int'($urandom_range(0, 1000)) - 200, int'($urandom_range(0, 400)) - 200,
             int'($urandom_range(0, 200)) - 100);
      end
    end
    wait_done();

    // reset in the middle of pass 1, then a fresh run over the stale buffer
    d0 = done_cnt;
    start(3, 4, 0);
    for (int i = 0; i < 4; i++) send(i, 30 + i, 0, 0);
    send(0, 1, 0, 0);
    send(1, 1, 0, 0);
    rst = 1'b1;
    tick();
    chk("mrst_rdy", int'(mac_rdy), 0);
    chk("mrst_wen", int'(omap_wen), 0);
    chk("mrst_waddr", int'(omap_waddr), 0);
    chk("mrst_wdata", int'(omap_wdata), 0);
    rst = 1'b0;
    repeat (8) tick();
    chk("mrst_no_done", done_cnt - d0, 0);
    start(2, 2, 1);
    for (int p = 0; p < 2; p++) begin
      send(0, 7, 0, 0);
      send(1, 9, 0, 0);
    end
    wait_done();
    chk("fresh_a0", int'(lit_out[0]), 7);
    chk("fresh_a1", int'(lit_out[1]), 9);

    // degenerate configurations complete immediately without writes
    d0 = done_cnt;
    w0 = wr_cnt;
    start(0, 4, 0);
    repeat (3) tick();
    start(2, 0, 0);
    repeat (3) tick();
    chk("zero_done_cnt", done_cnt - d0, 2);
    chk("zero_writes", wr_cnt - w0, 0);

    // out-of-range beat is consumed, flags the run and writes nothing
    lit_out[0] = 8'h55;
    w0 = wr_cnt;
    start(1, 2, 0);
    send(4096, 5, 0, 0);
    send(1, 8, 0, 0);
    wait_done();
    chk("oob_err", int'(acc_err), 1);
    chk("oob_writes", wr_cnt - w0, 1);
    chk("oob_a1", int'(lit_out[1]), 8);
    chk("oob_a0_untouched", int'(lit_out[0]), 85);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
